// File: rtl/phase_sequencer.sv
// Four-phase CPU sequencer: one-hot FT/DC/EX/WB enables, run/step/halt control,
// and arbitration of the shared RAM between the CPU and a host between instructions.
module phase_sequencer #(
  parameter int         CNT_W      = 16,
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             CLEAR_HALT,
  input  logic [3:0]       OP_CODE,
  input  logic             HOST_REQ,
  output logic             HOST_GNT,
  output logic             EN_FT,
  output logic             EN_DC,
  output logic             EN_EX,
  output logic             EN_WB,
  output logic             HALTED,
  output logic             BUSY,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FT,
    S_DC,
    S_EX,
    S_WB,
    S_HALT,
    S_HOST
  } state_t;

  state_t state;
  state_t ret_state;
  state_t nxt;
  logic   halt_flag;

  // NOTE: every branch starts from a default so no latch is inferred.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (HOST_REQ)         nxt = S_HOST;
        else if (RUN || STEP) nxt = S_FT;
      end
      S_FT: nxt = S_DC;
      S_DC: nxt = S_EX;
      S_EX: nxt = S_WB;
      S_WB: begin
        if (halt_flag)     nxt = S_HALT;
        else if (HOST_REQ) nxt = S_HOST;
        else if (RUN)      nxt = S_FT;
        else               nxt = S_IDLE;
      end
      S_HALT: begin
        if (CLEAR_HALT)    nxt = S_IDLE;
        else if (HOST_REQ) nxt = S_HOST;
      end
      S_HOST: begin
        if (!HOST_REQ) nxt = ret_state;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they always equal a decode
  // of the state register and never depend combinationally on inputs.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      halt_flag <= 1'b0;
      INSTR_CNT <= '0;
      EN_FT     <= 1'b0;
      EN_DC     <= 1'b0;
      EN_EX     <= 1'b0;
      EN_WB     <= 1'b0;
      HALTED    <= 1'b0;
      BUSY      <= 1'b0;
      HOST_GNT  <= 1'b0;
    end else begin
      state <= nxt;

      if (state == S_EX)
        halt_flag <= (OP_CODE == HLT_OPCODE);
      else if (state == S_HALT && CLEAR_HALT)
        halt_flag <= 1'b0;

      if (state == S_WB)
        INSTR_CNT <= INSTR_CNT + CNT_W'(1);

      // Remember where to go once the host releases the RAM.
      if (nxt == S_HOST && state != S_HOST)
        ret_state <= (state == S_HALT) ? S_HALT : S_IDLE;

      EN_FT    <= (nxt == S_FT);
      EN_DC    <= (nxt == S_DC);
      EN_EX    <= (nxt == S_EX);
      EN_WB    <= (nxt == S_WB);
      HALTED   <= (nxt == S_HALT);
      BUSY     <= (nxt == S_FT) || (nxt == S_DC) || (nxt == S_EX) || (nxt == S_WB);
      HOST_GNT <= (nxt == S_HOST);
    end
  end

endmodule
